// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard/forwarding controller: N-stage operand forwarding, per-register
// load scoreboard and HI/LO busy tracking. Optional perf counters under HAZ_PERF_CNT_EN.
module id_hazard_ctrl #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NFWD     = 2,
  parameter int LOAD_LAT = 2,
  parameter int MD_LAT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               ex_ready,
  input  logic               flush,
  input  logic               rs_used,
  input  logic               rt_used,
  input  logic [AW-1:0]      rs,
  input  logic [AW-1:0]      rt,
  input  logic               rf_we,
  input  logic [AW-1:0]      waddr,
  input  logic               is_load,
  input  logic               is_md,
  input  logic               hilo_re,
  input  logic [DW-1:0]      rdata1,
  input  logic [DW-1:0]      rdata2,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  input  logic [NFWD*DW-1:0] fwd_wdata,
  output logic [DW-1:0]      src1_data,
  output logic [DW-1:0]      src2_data,
  output logic               stallreq,
  output logic               issue_fire,
  output logic               md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        md_stall_cycles
`endif
);

  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(LOAD_LAT + 1);
  localparam int MW   = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT);
  localparam logic [MW-1:0] MD_INIT   = MW'(MD_LAT);

  logic [CW-1:0] sb_cnt [NREG];
  logic [MW-1:0] md_cnt;
  logic          rs_hz;
  logic          rt_hz;
  logic          md_hz;
  logic          load_set;

  // Handshake: the instruction in ID leaves (issue_fire) only when it is valid, not
  // flushed, hazard-free and EX is ready; state updates on the following rising edge.
  assign rs_hz      = rs_used && (rs != '0) && (sb_cnt[rs] != '0);
  assign rt_hz      = rt_used && (rt != '0) && (sb_cnt[rt] != '0);
  assign md_busy    = (md_cnt != '0);
  assign md_hz      = (hilo_re || is_md) && md_busy;
  assign stallreq   = id_valid && !flush && (rs_hz || rt_hz || md_hz);
  assign issue_fire = id_valid && ex_ready && !stallreq && !flush;
  assign load_set   = issue_fire && rf_we && is_load && (waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) sb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (load_set && (waddr == AW'(i))) sb_cnt[i] <= LOAD_INIT;
        else if (sb_cnt[i] != '0)          sb_cnt[i] <= sb_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     md_cnt <= '0;
    else if (issue_fire && is_md) md_cnt <= MD_INIT;
    else if (md_cnt != '0)        md_cnt <= md_cnt - 1'b1;
  end

  // Walk from oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    src1_data = rdata1;
    src2_data = rdata2;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_waddr[k*AW +: AW] == rs)) src1_data = fwd_wdata[k*DW +: DW];
      if (fwd_we[k] && (fwd_waddr[k*AW +: AW] == rt)) src2_data = fwd_wdata[k*DW +: DW];
    end
    if (rs == '0) src1_data = '0;
    if (rt == '0) src2_data = '0;
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stallreq)                      stall_cycles    <= stall_cycles + 32'd1;
      if (stallreq && !(rs_hz || rt_hz)) md_stall_cycles <= md_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Parametrised decode-stage hazard and forwarding controller; sits beside the ID stage between the regfile read ports and the ID-to-EX register.
- Replaces the fixed two-source forward chain and single-cycle load-use check with:
  - an N-stage forwarding network;
  - a per-register scoreboard with configurable load latency;
  - a HI/LO multi-cycle mult/div busy tracker.
- Produces forwarded operands, stallreq and the issue handshake.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width; 2**AW registers, register 0 hard-wired to zero.
- NFWD, 2, number of forwarding stage buses; index 0 is youngest (EX), NFWD-1 oldest.
- LOAD_LAT, 2, cycles after issue before a load result is forwardable; must be at least 1.
- MD_LAT, 4, cycles after issue before a mult/div HI/LO result is readable; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a decoded instruction.
- ex_ready  in  1  EX can accept an instruction this cycle.
- flush  in  1  kill the instruction in ID; it never issues.
- rs_used, rt_used  in  1 each  instruction reads rs / rt.
- rs, rt  in  AW each  source register addresses.
- rf_we  in  1  instruction writes the regfile.
- waddr  in  AW  destination register.
- is_load  in  1  instruction is a load.
- is_md  in  1  instruction is mult/div (writes HI/LO).
- hilo_re  in  1  instruction is mfhi/mflo.
- rdata1, rdata2  in  DW each  regfile read data.
- fwd_we  in  NFWD  per-stage write enable.
- fwd_waddr  in  NFWD*AW  per-stage destination, flattened, stage 0 in the LSBs.
- fwd_wdata  in  NFWD*DW  per-stage result, flattened the same way.
- src1_data, src2_data  out  DW each  forwarded operands.
- stallreq  out  1  hazard detected; ID must hold.
- issue_fire  out  1  instruction leaves ID this cycle.
- md_busy  out  1  HI/LO result pending.

Behaviour:
- Reset (rst=0, asynchronous): all scoreboard counters = 0 and md_cnt = 0. Consequently md_busy=0, stallreq=0 and issue_fire=0 while id_valid=0.
- Scoreboard: one counter per register, width $clog2(LOAD_LAT+1).
  - On issue_fire with rf_we & is_load & waddr!=0, the counter for waddr loads LOAD_LAT.
  - On each other cycle, every nonzero counter decrements by 1.
  - If an issue targets a register whose counter is nonzero, the load value overrides the decrement.
  - Non-load writes never set the scoreboard; they are covered by forwarding.
- md_cnt: on issue_fire with is_md, md_cnt loads MD_LAT; otherwise it decrements while nonzero. md_busy = (md_cnt != 0).
- stallreq is combinational and is 1 when id_valid & ~flush and any of the following holds:
  - rs_used & rs!=0 & counter[rs]!=0;
  - rt_used & rt!=0 & counter[rt]!=0;
  - hilo_re & md_busy;
  - is_md & md_busy (structural hazard on the mult/div unit).
- issue_fire = id_valid & ex_ready & ~stallreq & ~flush. It is combinational; the scoreboard updates on the next rising edge.
- Forwarding for each source, combinational:
  - address 0 returns 0;
  - otherwise take the lowest-index stage k with fwd_we[k] and fwd_waddr[k] equal to the source;
  - otherwise take rdata1 / rdata2.
  - The youngest stage wins when several stages match.
- Boundary conditions:
  - A counter reaching 0 in the same cycle as a dependent read: stall is evaluated on the current (pre-decrement) value, so the dependent instruction issues one cycle later. A load issued at cycle t therefore lets a dependent instruction issue at t+LOAD_LAT+1 at the earliest.
  - flush with id_valid: no issue, no stall, no scoreboard set. Pending counters continue, because older loads are still in flight.
  - ex_ready=0 without a hazard: stallreq=0, issue_fire=0, state unchanged apart from the normal decrement.
  - Reset mid-operation: all pending state clears immediately.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cycles, 32 bits: increments each cycle stallreq=1.
  - md_stall_cycles, 32 bits: increments each cycle stallreq=1 caused only by the HI/LO or mult/div conditions.
  - Both reset to 0 and wrap at 2**32-1 to 0.
- When undefined, the ports and counters are absent and there is zero added logic.

Test Plan:
- Forwarding priority: fwd_we=2'b11, both stage waddrs=5, wdata stage0=0x11, stage1=0x22, rs=5, rdata1=0x33 -> src1_data=0x11. Then drop fwd_we[0] -> src1_data=0x22.
- Load-use, LOAD_LAT=2: issue lw $8 at cycle 0; dependent add reads $8 with ex_ready=1 -> stallreq=1 in cycles 1-2, issue_fire=1 in cycle 3.
- Register zero: lw $0 issued, next instruction reads $0 -> no stall, src1_data=0 even with fwd_we[0]=1 and fwd_waddr=0 carrying 0xDEAD.
- HI/LO, MD_LAT=4: mult issued at cycle 0 -> md_busy high cycles 1-4; mfhi held with stallreq=1 through cycle 4, issues at cycle 5. A second mult at cycle 1 also stalls.
- Flush and reset: flush=1 on a load -> no counter set, next reader not stalled. Assert rst=0 while counter[8]=2 -> counter cleared asynchronously, reader issues the first cycle after rst=1.
- With HAZ_PERF_CNT_EN, in the load-use case -> stall_cycles=2, md_stall_cycles=0.
